// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: shares one downstream cache-bus port between the fetch
// unit (requester 0) and the LSU/dcache (requester 1). A granted request
// holds the bus through its request, write-data and response phases.
// Handshakes and data are passed through combinationally.
module core_bus_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int LEN_WIDTH    = 4,
    parameter int LSU_PRIORITY = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     s_req_valid_i,
    output logic [1:0]                     s_req_ready_o,
    input  logic [1:0][ADDR_WIDTH-1:0]     s_req_addr_i,
    input  logic [1:0]                     s_req_write_i,
    input  logic [1:0][LEN_WIDTH-1:0]      s_req_len_i,
    input  logic [1:0]                     s_req_uncached_i,
    input  logic [1:0]                     s_wvalid_i,
    output logic [1:0]                     s_wready_o,
    input  logic [1:0][DATA_WIDTH-1:0]     s_wdata_i,
    input  logic [1:0][DATA_WIDTH/8-1:0]   s_wstrb_i,
    output logic [1:0]                     s_rvalid_o,
    output logic [1:0]                     s_rlast_o,
    output logic [DATA_WIDTH-1:0]          s_rdata_o,
    output logic [1:0]                     s_bvalid_o,
    output logic                           m_req_valid_o,
    input  logic                           m_req_ready_i,
    output logic [ADDR_WIDTH-1:0]          m_req_addr_o,
    output logic                           m_req_write_o,
    output logic [LEN_WIDTH-1:0]           m_req_len_o,
    output logic                           m_req_uncached_o,
    output logic                           m_wvalid_o,
    input  logic                           m_wready_i,
    output logic [DATA_WIDTH-1:0]          m_wdata_o,
    output logic [DATA_WIDTH/8-1:0]        m_wstrb_o,
    output logic                           m_wlast_o,
    input  logic                           m_rvalid_i,
    input  logic [DATA_WIDTH-1:0]          m_rdata_i,
    input  logic                           m_rlast_i,
    input  logic                           m_bvalid_i,
    output logic                           bus_busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WDATA = 3'd2,
        ST_WRESP = 3'd3,
        ST_RDATA = 3'd4
    } state_t;

    state_t                  state_r;
    logic                    grant_r;
    logic                    last_grant_r;
    logic [LEN_WIDTH-1:0]    beat_cnt_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    write_r;
    logic [LEN_WIDTH-1:0]    len_r;
    logic                    uncached_r;
    logic                    winner_s;

    // Pick the requester to grant in IDLE (fixed LSU priority or alternating).
    always_comb begin
        winner_s = 1'b0;
        if (LSU_PRIORITY != 0) begin
            winner_s = s_req_valid_i[1];
        end else if (s_req_valid_i == 2'b11) begin
            winner_s = ~last_grant_r;
        end else begin
            winner_s = s_req_valid_i[1];
        end
    end

    // Route handshakes between the granted requester and the downstream port.
    always_comb begin
        s_req_ready_o = 2'b00;
        s_wready_o    = 2'b00;
        s_rvalid_o    = 2'b00;
        s_rlast_o     = 2'b00;
        s_bvalid_o    = 2'b00;
        m_wvalid_o    = 1'b0;
        m_wlast_o     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (s_req_valid_i != 2'b00) begin
                    s_req_ready_o[winner_s] = 1'b1;
                end else begin
                    s_req_ready_o = 2'b00;
                end
            end
            ST_WDATA: begin
                m_wvalid_o            = s_wvalid_i[grant_r];
                s_wready_o[grant_r]   = m_wready_i;
                m_wlast_o             = (beat_cnt_r == len_r);
            end
            ST_WRESP: begin
                s_bvalid_o[grant_r]   = m_bvalid_i;
            end
            ST_RDATA: begin
                s_rvalid_o[grant_r]   = m_rvalid_i;
                s_rlast_o[grant_r]    = m_rlast_i;
            end
            default: begin
                s_req_ready_o = 2'b00;
            end
        endcase
    end

    assign m_req_valid_o    = (state_r == ST_REQ);
    assign m_req_addr_o     = addr_r;
    assign m_req_write_o    = write_r;
    assign m_req_len_o      = len_r;
    assign m_req_uncached_o = uncached_r;
    assign m_wdata_o        = s_wdata_i[grant_r];
    assign m_wstrb_o        = s_wstrb_i[grant_r];
    assign s_rdata_o        = m_rdata_i;
    assign bus_busy_o       = (state_r != ST_IDLE);

    // Burst sequencing: grant, request phase, data/response phases, back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            beat_cnt_r   <= '0;
            addr_r       <= '0;
            write_r      <= 1'b0;
            len_r        <= '0;
            uncached_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (s_req_valid_i != 2'b00) begin
                        grant_r      <= winner_s;
                        last_grant_r <= winner_s;
                        beat_cnt_r   <= '0;
                        addr_r       <= s_req_addr_i[winner_s];
                        write_r      <= s_req_write_i[winner_s];
                        len_r        <= s_req_len_i[winner_s];
                        uncached_r   <= s_req_uncached_i[winner_s];
                        state_r      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (m_req_ready_i) begin
                        state_r <= write_r ? ST_WDATA : ST_RDATA;
                    end
                end
                ST_WDATA: begin
                    // The last beat leaves the state, so the counter never wraps.
                    if (m_wvalid_o && m_wready_i) begin
                        if (m_wlast_o) begin
                            state_r <= ST_WRESP;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_WRESP: begin
                    if (m_bvalid_i) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RDATA: begin
                    if (m_rvalid_i && m_rlast_i) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter. Instance A (LSU priority) runs randomized
// bursts against a downstream model with a grant-order scoreboard; instance B
// (round-robin) gets directed grant-order, mid-burst reset and stray-beat cases.
module tb_core_bus_arbiter;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] addr;
        logic        write;
        logic [3:0]  len;
        logic        unc;
    } txn_t;

    // ---------------- instance A signals ----------------
    logic a_rst;
    logic [1:0] a_req_valid, a_req_ready, a_req_write, a_req_unc;
    logic [1:0][31:0] a_req_addr;
    logic [1:0][3:0] a_req_len;
    logic [1:0] a_wvalid, a_wready, a_rvalid, a_rlast, a_bvalid;
    logic [1:0][31:0] a_wdata;
    logic [1:0][3:0] a_wstrb;
    logic [31:0] a_rdata;
    logic a_m_req_valid, a_m_req_ready, a_m_write, a_m_unc;
    logic [31:0] a_m_addr;
    logic [3:0] a_m_len;
    logic a_m_wvalid, a_m_wready, a_m_wlast;
    logic [31:0] a_m_wdata;
    logic [3:0] a_m_wstrb;
    logic a_m_rvalid, a_m_rlast, a_m_bvalid, a_busy;
    logic [31:0] a_m_rdata;

    // ---------------- instance B signals ----------------
    logic b_rst;
    logic [1:0] b_req_valid, b_req_ready, b_req_write, b_req_unc;
    logic [1:0][31:0] b_req_addr;
    logic [1:0][3:0] b_req_len;
    logic [1:0] b_wvalid, b_wready, b_rvalid, b_rlast, b_bvalid;
    logic [1:0][31:0] b_wdata;
    logic [1:0][3:0] b_wstrb;
    logic [31:0] b_rdata;
    logic b_m_req_valid, b_m_req_ready, b_m_write, b_m_unc;
    logic [31:0] b_m_addr;
    logic [3:0] b_m_len;
    logic b_m_wvalid, b_m_wready, b_m_wlast;
    logic [31:0] b_m_wdata;
    logic [3:0] b_m_wstrb;
    logic b_m_rvalid, b_m_rlast, b_m_bvalid, b_busy;
    logic [31:0] b_m_rdata;

    core_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(4), .LSU_PRIORITY(1)) dut_a (
        .clk(clk), .rst(a_rst),
        .s_req_valid_i(a_req_valid), .s_req_ready_o(a_req_ready), .s_req_addr_i(a_req_addr),
        .s_req_write_i(a_req_write), .s_req_len_i(a_req_len), .s_req_uncached_i(a_req_unc),
        .s_wvalid_i(a_wvalid), .s_wready_o(a_wready), .s_wdata_i(a_wdata), .s_wstrb_i(a_wstrb),
        .s_rvalid_o(a_rvalid), .s_rlast_o(a_rlast), .s_rdata_o(a_rdata), .s_bvalid_o(a_bvalid),
        .m_req_valid_o(a_m_req_valid), .m_req_ready_i(a_m_req_ready), .m_req_addr_o(a_m_addr),
        .m_req_write_o(a_m_write), .m_req_len_o(a_m_len), .m_req_uncached_o(a_m_unc),
        .m_wvalid_o(a_m_wvalid), .m_wready_i(a_m_wready), .m_wdata_o(a_m_wdata),
        .m_wstrb_o(a_m_wstrb), .m_wlast_o(a_m_wlast),
        .m_rvalid_i(a_m_rvalid), .m_rdata_i(a_m_rdata), .m_rlast_i(a_m_rlast),
        .m_bvalid_i(a_m_bvalid), .bus_busy_o(a_busy)
    );

    core_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(4), .LSU_PRIORITY(0)) dut_b (
        .clk(clk), .rst(b_rst),
        .s_req_valid_i(b_req_valid), .s_req_ready_o(b_req_ready), .s_req_addr_i(b_req_addr),
        .s_req_write_i(b_req_write), .s_req_len_i(b_req_len), .s_req_uncached_i(b_req_unc),
        .s_wvalid_i(b_wvalid), .s_wready_o(b_wready), .s_wdata_i(b_wdata), .s_wstrb_i(b_wstrb),
        .s_rvalid_o(b_rvalid), .s_rlast_o(b_rlast), .s_rdata_o(b_rdata), .s_bvalid_o(b_bvalid),
        .m_req_valid_o(b_m_req_valid), .m_req_ready_i(b_m_req_ready), .m_req_addr_o(b_m_addr),
        .m_req_write_o(b_m_write), .m_req_len_o(b_m_len), .m_req_uncached_o(b_m_unc),
        .m_wvalid_o(b_m_wvalid), .m_wready_i(b_m_wready), .m_wdata_o(b_m_wdata),
        .m_wstrb_o(b_m_wstrb), .m_wlast_o(b_m_wlast),
        .m_rvalid_i(b_m_rvalid), .m_rdata_i(b_m_rdata), .m_rlast_i(b_m_rlast),
        .m_bvalid_i(b_m_bvalid), .bus_busy_o(b_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] oh(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    // Write beat contents are a function of address and beat index.
    function automatic logic [31:0] wfun(input logic [31:0] a, input logic [3:0] b);
        return {a[23:0], 4'h0, b} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [3:0] sfun(input logic [31:0] a, input logic [3:0] b);
        return a[3:0] ^ b;
    endfunction

    // ---------------- instance A: scoreboard and downstream model ----------------
    txn_t exp_q[$];
    txn_t cur;
    logic mon_en = 1'b0;
    int   ds_phase = 0;          // 0 idle, 1 read beats, 2 write data, 3 write response
    logic [3:0] ds_beat = 4'd0;
    int   outstanding = 0;
    logic [1:0] hs_sreq = 2'b00, hs_sw = 2'b00;
    logic hs_req = 1'b0, hs_mw = 1'b0, grant_prev = 1'b0, done_prev = 1'b0;

    logic [1:0][31:0] r_addr;
    logic [1:0] r_write, r_unc, req_act, wr_act;
    logic [1:0][3:0] r_len;
    logic [1:0][3:0] wbeat;

    // Monitor: compares instance A outputs against the scoreboard every cycle.
    initial begin
        logic [1:0] exp2;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (grant_prev) begin
                    chk("m_req_valid_after_grant", 64'(a_m_req_valid), 64'(1'b1));
                    chk("m_req_addr", 64'(a_m_addr), 64'(cur.addr));
                    chk("m_req_write", 64'(a_m_write), 64'(cur.write));
                    chk("m_req_len", 64'(a_m_len), 64'(cur.len));
                    chk("m_req_uncached", 64'(a_m_unc), 64'(cur.unc));
                    chk("busy_after_grant", 64'(a_busy), 64'(1'b1));
                    grant_prev = 1'b0;
                end
                if (done_prev) begin
                    chk("busy_after_done", 64'(a_busy), 64'(1'b0));
                    chk("idle_gap_no_req", 64'(a_m_req_valid), 64'(1'b0));
                    done_prev = 1'b0;
                end
                if (ds_phase != 0) begin
                    chk("no_grant_while_busy", 64'(a_req_ready), 64'(2'b00));
                    chk("busy_in_burst", 64'(a_busy), 64'(1'b1));
                end else if (a_req_ready != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_grant: actual %0h required none", a_req_ready);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("grant_order", 64'(a_req_ready), 64'(oh(cur.id)));
                        chk("busy_at_grant", 64'(a_busy), 64'(1'b0));
                        grant_prev = 1'b1;
                    end
                end
                exp2 = (ds_phase == 2) ? oh(cur.id) & {2{a_wvalid[cur.id]}} : 2'b00;
                chk("m_wvalid", 64'(a_m_wvalid), 64'(exp2 != 2'b00));
                exp2 = (ds_phase == 2 && a_m_wready) ? oh(cur.id) : 2'b00;
                chk("s_wready", 64'(a_wready), 64'(exp2));
                hs_mw = (ds_phase == 2) && a_m_wvalid && a_m_wready;
                if (hs_mw) begin
                    chk("m_wdata", 64'(a_m_wdata), 64'(wfun(cur.addr, ds_beat)));
                    chk("m_wstrb", 64'(a_m_wstrb), 64'(sfun(cur.addr, ds_beat)));
                    chk("m_wlast", 64'(a_m_wlast), 64'(ds_beat == cur.len));
                end
                exp2 = (ds_phase == 1 && a_m_rvalid) ? oh(cur.id) : 2'b00;
                chk("s_rvalid", 64'(a_rvalid), 64'(exp2));
                if (exp2 != 2'b00) begin
                    chk("s_rdata", 64'(a_rdata), 64'(a_m_rdata));
                end
                exp2 = (ds_phase == 1 && a_m_rlast) ? oh(cur.id) : 2'b00;
                chk("s_rlast", 64'(a_rlast), 64'(exp2));
                exp2 = (ds_phase == 3 && a_m_bvalid) ? oh(cur.id) : 2'b00;
                chk("s_bvalid", 64'(a_bvalid), 64'(exp2));
                hs_req    = a_m_req_valid && a_m_req_ready;
                hs_sreq   = a_req_valid & a_req_ready;
                hs_sw     = a_wvalid & a_wready;
                done_prev = (ds_phase == 1 && a_m_rvalid && a_m_rlast) ||
                            (ds_phase == 3 && a_m_bvalid);
            end
        end
    end

    int rounds_left = 120;

    // One cycle of instance A stimulus: requesters and the downstream model.
    task automatic a_step();
        logic [1:0] mask;
        txn_t t;
        @(posedge clk);
        #1;
        for (int r = 0; r < 2; r++) begin
            if (hs_sreq[r]) begin
                req_act[r] = 1'b0;
                wr_act[r]  = r_write[r];
                wbeat[r]   = 4'd0;
            end
            if (hs_sw[r]) begin
                if (wbeat[r] == r_len[r]) wr_act[r] = 1'b0;
                wbeat[r] = wbeat[r] + 4'd1;
            end
        end
        case (ds_phase)
            0: if (hs_req) begin ds_phase = cur.write ? 2 : 1; ds_beat = 4'd0; end
            1: if (a_m_rvalid) begin
                   if (a_m_rlast) begin ds_phase = 0; outstanding--; end
                   else ds_beat = ds_beat + 4'd1;
               end
            2: if (hs_mw) begin
                   if (ds_beat == cur.len) ds_phase = 3;
                   else ds_beat = ds_beat + 4'd1;
               end
            3: if (a_m_bvalid) begin ds_phase = 0; outstanding--; end
            default: ds_phase = 0;
        endcase
        if (outstanding == 0 && rounds_left > 0 && $urandom_range(0, 2) == 0) begin
            rounds_left--;
            mask = 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                if (mask[r]) begin
                    r_addr[r]  = $urandom;
                    r_write[r] = 1'($urandom_range(0, 1));
                    r_len[r]   = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
                    r_unc[r]   = 1'($urandom_range(0, 1));
                    req_act[r] = 1'b1;
                    outstanding++;
                end
            end
            // LSU priority: requester 1 is served first whenever it asks.
            for (int k = 0; k < 2; k++) begin
                int r;
                r = (k == 0) ? 1 : 0;
                if (mask[r]) begin
                    t.id = 1'(r); t.addr = r_addr[r]; t.write = r_write[r];
                    t.len = r_len[r]; t.unc = r_unc[r];
                    exp_q.push_back(t);
                end
            end
        end
        for (int r = 0; r < 2; r++) begin
            a_req_valid[r] = req_act[r];
            a_req_addr[r]  = r_addr[r];
            a_req_write[r] = r_write[r];
            a_req_len[r]   = r_len[r];
            a_req_unc[r]   = r_unc[r];
            a_wvalid[r]    = wr_act[r] && ($urandom_range(0, 3) != 0);
            a_wdata[r]     = wfun(r_addr[r], wbeat[r]);
            a_wstrb[r]     = sfun(r_addr[r], wbeat[r]);
        end
        a_m_req_ready = 1'($urandom_range(0, 1));
        a_m_rvalid = 1'b0; a_m_rlast = 1'b0; a_m_wready = 1'b0; a_m_bvalid = 1'b0;
        a_m_rdata = $urandom;
        case (ds_phase)
            0: begin
                   a_m_rvalid = ($urandom_range(0, 7) == 0);
                   a_m_rlast  = 1'($urandom_range(0, 1));
                   a_m_bvalid = ($urandom_range(0, 7) == 0);
               end
            1: begin
                   a_m_rvalid = ($urandom_range(0, 3) != 0);
                   a_m_rlast  = (ds_beat == cur.len);
               end
            2: a_m_wready = 1'($urandom_range(0, 1));
            3: a_m_bvalid = ($urandom_range(0, 2) == 0);
            default: a_m_rvalid = 1'b0;
        endcase
    endtask

    // ---------------- instance B directed helpers ----------------
    task automatic b_wait_idle();
        int c;
        c = 0;
        while (b_busy && c < 40) begin
            @(posedge clk);
            #1;
            c++;
        end
        @(negedge clk);
        chk("b_idle_after_round", 64'(b_busy), 64'(1'b0));
        @(posedge clk);
        #1;
    endtask

    // Present a set of requests and check the order in which they are granted.
    task automatic b_round(input logic [1:0] mask, input logic first, input logic second);
        int n, need;
        logic [1:0] g;
        need = (mask == 2'b11) ? 2 : 1;
        n = 0;
        b_req_valid = mask;
        b_m_rvalid = 1'b1;
        b_m_rlast = 1'b1;
        for (int c = 0; c < 40 && n < need; c++) begin
            @(negedge clk);
            g = b_req_ready;
            if (g != 2'b00) begin
                chk("rr_grant", 64'(g), 64'(oh((n == 0) ? first : second)));
                n++;
            end
            @(posedge clk);
            #1;
            b_req_valid = b_req_valid & ~g;
        end
        if (n < need) begin
            vectors++;
            miscompares++;
            $display("FAIL rr_grant_timeout: actual %0d grants required %0d", n, need);
        end
        b_req_valid = 2'b00;
        b_wait_idle();
    endtask

    task automatic b_reset_mid_read();
        int beats;
        beats = 0;
        b_m_rlast = 1'b0;
        b_m_rvalid = 1'b1;
        b_req_len[0] = 4'd3;
        b_req_valid = 2'b01;
        for (int c = 0; c < 20 && beats < 2; c++) begin
            @(negedge clk);
            if (b_rvalid[0]) beats++;
            if (b_req_ready != 2'b00) begin
                @(posedge clk);
                #1;
                b_req_valid = 2'b00;
            end else if (beats < 2) begin
                @(posedge clk);
                #1;
            end
        end
        chk("b_two_beats_seen", 64'(beats), 64'(2));
        @(posedge clk);
        #1;
        b_rst = 1'b1;
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 64'(b_busy), 64'(1'b0));
        chk("rst_mid_rvalid", 64'(b_rvalid), 64'(2'b00));
        chk("rst_mid_rlast", 64'(b_rlast), 64'(2'b00));
        chk("rst_mid_mreq", 64'(b_m_req_valid), 64'(1'b0));
        chk("rst_mid_ready", 64'(b_req_ready), 64'(2'b00));
        // Stray read beat in IDLE: not forwarded, no state change.
        b_m_rlast = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stray_rvalid", 64'(b_rvalid), 64'(2'b00));
        chk("stray_busy", 64'(b_busy), 64'(1'b0));
        @(posedge clk);
        #1;
        b_req_addr[1] = 32'hCAFE_0040;
        b_req_valid = 2'b10;
        @(negedge clk);
        chk("fresh_grant", 64'(b_req_ready), 64'(2'b10));
        @(posedge clk);
        #1;
        b_req_valid = 2'b00;
        @(negedge clk);
        chk("fresh_mreq_valid", 64'(b_m_req_valid), 64'(1'b1));
        chk("fresh_mreq_addr", 64'(b_m_addr), 64'(32'hCAFE_0040));
        @(posedge clk);
        #1;
        b_wait_idle();
    endtask

    // Main sequence: reset checks, directed instance B, randomized instance A.
    initial begin
        int cyc;
        a_rst = 1'b1; b_rst = 1'b1;
        a_req_valid = 2'b00; a_req_addr = '0; a_req_write = 2'b00; a_req_len = '0; a_req_unc = 2'b00;
        a_wvalid = 2'b00; a_wdata = '0; a_wstrb = '0;
        a_m_req_ready = 1'b0; a_m_wready = 1'b0; a_m_rvalid = 1'b0; a_m_rdata = 32'd0;
        a_m_rlast = 1'b0; a_m_bvalid = 1'b0;
        b_req_valid = 2'b00; b_req_addr = '0; b_req_write = 2'b00; b_req_len = '0; b_req_unc = 2'b00;
        b_wvalid = 2'b00; b_wdata = '0; b_wstrb = '0;
        b_m_req_ready = 1'b1; b_m_wready = 1'b1; b_m_rvalid = 1'b0; b_m_rdata = 32'h1234_5678;
        b_m_rlast = 1'b0; b_m_bvalid = 1'b0;
        r_addr = '0; r_write = 2'b00; r_unc = 2'b00; req_act = 2'b00; wr_act = 2'b00;
        r_len = '0; wbeat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_busy", 64'(a_busy), 64'(1'b0));
        chk("rst_a_ready", 64'(a_req_ready), 64'(2'b00));
        chk("rst_a_mreq", 64'(a_m_req_valid), 64'(1'b0));
        chk("rst_a_mwvalid", 64'(a_m_wvalid), 64'(1'b0));
        chk("rst_a_mwlast", 64'(a_m_wlast), 64'(1'b0));
        chk("rst_a_outs", 64'({a_rvalid, a_rlast, a_bvalid, a_wready}), 64'(8'h00));
        chk("rst_b_busy", 64'(b_busy), 64'(1'b0));
        chk("rst_b_ready", 64'(b_req_ready), 64'(2'b00));
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        @(posedge clk);
        #1;
        // Round-robin from reset favours requester 0, then alternates.
        b_round(2'b11, 1'b0, 1'b1);
        b_round(2'b01, 1'b0, 1'b0);
        b_round(2'b11, 1'b1, 1'b0);
        b_reset_mid_read();

        a_rst = 1'b0;
        mon_en = 1'b1;
        cyc = 0;
        while ((rounds_left > 0 || outstanding > 0) && cyc < 20000) begin
            a_step();
            cyc++;
        end
        repeat (3) a_step();
        if (outstanding != 0 || exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: actual %0d outstanding, %0d ungranted required 0",
                     outstanding, exp_q.size());
        end
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
